mem_arbiter_2p: RTL and testbench
=================================

Name: mem_arbiter_2p

Overview:
- Parametrised, sequential two-port arbiter. The instruction-fetch port (I) and the load/store port (D) share one single-ported, fixed-latency memory.
- Replaces the stall-steered combinational mux with a req/gnt/rvalid protocol, a selectable arbitration policy, read-latency tracking and instruction-response flush.
- Sits between the core's fetch/LSU and the unified memory.

Parameters:
- ADDR_W, 32, address width (all address ports).
- DATA_W, 32, data width; must be a multiple of 8.
- BE_W, DATA_W/8, byte-enable width.
- MEM_LAT, 1, memory read latency in cycles (>=1); m_rdata is valid MEM_LAT cycles after the issue cycle.
- PRIO_MODE, 0, arbitration policy: 0 = D fixed priority, 1 = round-robin.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- i_req  in  1  instruction read request
- i_addr  in  ADDR_W  instruction address
- i_flush  in  1  discard in-flight/issuing instruction response
- i_gnt  out  1  I request accepted this cycle
- i_rvalid  out  1  instruction data valid
- i_rdata  out  DATA_W  instruction data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  BE_W  byte enables
- d_gnt  out  1  D request accepted this cycle
- d_rvalid  out  1  load data valid (reads only)
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory access issued this cycle
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_be  out  BE_W  memory byte enables (all-ones for I reads)
- m_rdata  in  DATA_W  memory read data

Behaviour:
- Reset: while rst=1 all outputs are 0. State -> IDLE, cnt=0, owner=D, last=D, drop=0.
- Protocol:
  - A requester holds req and its attributes stable until it sees gnt.
  - gnt is combinational, from req and state, in the issue cycle T.
  - m_* are driven from the granted port in cycle T. m_req=0 and m_* = 0 when nothing is granted.
- States:
  - IDLE: no read outstanding.
  - BUSY: read outstanding; cnt counts 1..MEM_LAT.
- Grant eligibility:
  - Grants are allowed in IDLE.
  - Grants are also allowed in the BUSY cycle where cnt==MEM_LAT (the response cycle), so throughput is one read per MEM_LAT cycles.
  - With MEM_LAT=1, back-to-back reads issue every cycle.
  - No grant occurs in other BUSY cycles.
- Arbitration on simultaneous i_req & d_req:
  - PRIO_MODE=0: D wins.
  - PRIO_MODE=1: the port that is not `last` wins. `last` updates on every grant. Because last resets to D, the first conflict goes to I.
- Flush gating: i_flush=1 blocks an I grant in that cycle; D may still be granted.
- Read issue: owner <- granted port, cnt <- 1, state -> BUSY.
- Write issue (d_we=1): completes in cycle T with m_we=1 and no rvalid. State stays or returns to IDLE unless a read is also outstanding. A write is only issued when a grant is eligible.
- BUSY: cnt increments each cycle. When cnt==MEM_LAT:
  - the owner's rvalid=1 and rdata=m_rdata (combinational);
  - state -> IDLE, or re-enters BUSY if a new read is granted the same cycle.
- Non-owner outputs: the non-owner rvalid=0 and its rdata=0.
- Flush of I responses:
  - i_flush=1 while owner=I and BUSY sets drop=1.
  - At the response cycle, drop=1 forces i_rvalid=0 and i_rdata=0; drop clears at that cycle.
  - i_flush has no effect on a D transaction.
- Reset mid-transaction: the outstanding response is lost, and no rvalid follows reset release.

Test Plan:
- MEM_LAT=1, PRIO_MODE=0: i_req alone, i_addr=0x100 for 3 cycles, m_rdata = addr+1 -> m_addr 0x100,0x104,0x108 issued on consecutive cycles; i_rvalid one cycle after each issue with i_rdata 0x101,0x105,0x109.
- PRIO_MODE=0: i_req & d_req (read, d_addr=0x2000) together -> d_gnt=1, i_gnt=0; next eligible cycle i_gnt=1. d_rvalid precedes i_rvalid.
- PRIO_MODE=1, MEM_LAT=1: both requesting continuously for 4 cycles -> grants I,D,I,D.
- MEM_LAT=3: D read at T -> d_gnt T, d_rvalid only at T+3. An i_req held through T+1..T+2 gets no i_gnt until T+3.
- D write d_be=0x3, d_wdata=0xA5A5_1234 -> m_we=1, m_be=0x3 in the issue cycle; d_rvalid never asserts. A pending i_req is granted the next cycle.
- MEM_LAT=2: I read at T, i_flush at T+1 -> i_rvalid=0 at T+2. Separately, rst asserted at T+1 -> all outputs 0, and no rvalid after release.

Source files
------------

// File: rtl/mem_arbiter_2p_if.sv
// Bundle of the fetch port, load/store port and memory port that meet at mem_arbiter_2p.
// slave is the arbiter's view; master is the view of the core/memory side driving it.
interface mem_arbiter_2p_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
);
  // req/gnt: a requester holds req and its attributes stable until gnt is seen;
  // gnt is a same-cycle acceptance and the memory access is issued in that cycle.
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [BE_W-1:0]   m_be;
  logic [DATA_W-1:0] m_rdata;
  logic [0:0]        fsm_state;

  modport slave (
    input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_be, fsm_state
  );

  modport master (
    output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_be, fsm_state
  );
endinterface

// File: rtl/mem_arbiter_2p.sv
// Two-port (fetch / load-store) arbiter in front of a single-ported fixed-latency memory,
// with selectable D-priority or round-robin policy and fetch-response flush.
module mem_arbiter_2p #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BE_W      = DATA_W / 8,
  parameter int MEM_LAT   = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_2p_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BUSY  = 1'b1;
  localparam logic       OWN_D = 1'b0;
  localparam logic       OWN_I = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last;
  logic             drop;

  logic resp, elig, i_cand, d_win, gnt_i, gnt_d, rd_issue;

  always_comb begin
    resp     = (state == BUSY) && (cnt == LAT_C);
    // The response cycle is also an issue slot, giving one read per MEM_LAT cycles.
    elig     = !rst && ((state == IDLE) || resp);
    i_cand   = bus.i_req && !bus.i_flush;
    d_win    = (PRIO_MODE == 0) || (last == OWN_I);
    gnt_d    = elig && bus.d_req && (!i_cand || d_win);
    gnt_i    = elig && i_cand && !gnt_d;
    rd_issue = gnt_i || (gnt_d && !bus.d_we);
  end

  always_comb begin
    bus.i_gnt     = gnt_i;
    bus.d_gnt     = gnt_d;
    bus.m_req     = gnt_i || gnt_d;
    bus.m_we      = gnt_d && bus.d_we;
    bus.m_addr    = '0;
    bus.m_wdata   = '0;
    bus.m_be      = '0;
    if (gnt_d) begin
      bus.m_addr  = bus.d_addr;
      bus.m_wdata = bus.d_wdata;
      bus.m_be    = bus.d_be;
    end else if (gnt_i) begin
      bus.m_addr  = bus.i_addr;
      bus.m_be    = '1;
    end
    // rst gating matters: state may still read BUSY during the cycle reset is applied.
    bus.d_rvalid  = !rst && resp && (owner == OWN_D);
    bus.i_rvalid  = !rst && resp && (owner == OWN_I) && !drop;
    bus.d_rdata   = bus.d_rvalid ? bus.m_rdata : '0;
    bus.i_rdata   = bus.i_rvalid ? bus.m_rdata : '0;
    bus.fsm_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= OWN_D;
      last  <= OWN_D;
      drop  <= 1'b0;
    end else begin
      if (gnt_i || gnt_d) begin
        last <= gnt_i ? OWN_I : OWN_D;
      end
      if (rd_issue) begin
        state <= BUSY;
        cnt   <= ONE_C;
        owner <= gnt_i ? OWN_I : OWN_D;
        drop  <= 1'b0;
      end else if (resp) begin
        state <= IDLE;
        cnt   <= '0;
        drop  <= 1'b0;
      end else if (state == BUSY) begin
        cnt <= cnt + ONE_C;
        if (bus.i_flush && (owner == OWN_I)) begin
          drop <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Bench for mem_arbiter_2p: four instances (lat/prio = 1/0, 1/1, 3/0, 2/0) exercised one at a time,
// with a memory model returning addr+1 and a scoreboard of expected read responses.
module tb_mem_arbiter_2p;
  logic        clk;
  logic [3:0]  rst;
  logic [3:0]  i_req, i_flush, d_req, d_we;
  logic [3:0]  i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, fsm_state;
  logic [31:0] i_addr [4];
  logic [31:0] d_addr [4];
  logic [31:0] d_wdata [4];
  logic [3:0]  d_be [4];
  logic [31:0] i_rdata [4];
  logic [31:0] d_rdata [4];
  logic [31:0] m_addr [4];
  logic [31:0] m_wdata [4];
  logic [3:0]  m_be [4];

  logic [31:0] cyc;
  int          cur;
  int          n_checks;
  int          n_errors;
  logic [31:0] i_exp_q[$];
  logic [31:0] i_due_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] d_due_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  for (genvar k = 0; k < 4; k++) begin : g
    localparam int L = (k == 2) ? 3 : (k == 3) ? 2 : 1;
    localparam int P = (k == 1) ? 1 : 0;
    mem_arbiter_2p_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    logic [31:0] pipe [L];

    assign bus.i_req    = i_req[k];
    assign bus.i_addr   = i_addr[k];
    assign bus.i_flush  = i_flush[k];
    assign bus.d_req    = d_req[k];
    assign bus.d_we     = d_we[k];
    assign bus.d_addr   = d_addr[k];
    assign bus.d_wdata  = d_wdata[k];
    assign bus.d_be     = d_be[k];
    assign bus.m_rdata  = pipe[L-1] + 32'd1;
    assign i_gnt[k]     = bus.i_gnt;
    assign d_gnt[k]     = bus.d_gnt;
    assign i_rvalid[k]  = bus.i_rvalid;
    assign d_rvalid[k]  = bus.d_rvalid;
    assign i_rdata[k]   = bus.i_rdata;
    assign d_rdata[k]   = bus.d_rdata;
    assign m_req[k]     = bus.m_req;
    assign m_we[k]      = bus.m_we;
    assign m_addr[k]    = bus.m_addr;
    assign m_wdata[k]   = bus.m_wdata;
    assign m_be[k]      = bus.m_be;
    assign fsm_state[k] = bus.fsm_state[0];

    // memory model: data for an address issued at T appears L cycles later
    always @(posedge clk) begin
      pipe[0] <= bus.m_addr;
      for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
    end

    mem_arbiter_2p #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .PRIO_MODE(P)) dut (
      .clk (clk),
      .rst (rst[k]),
      .bus (bus)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h (dut %0d, cycle %0d)", tag, obs, exp, cur, cyc);
    end
  endtask

  function automatic logic [31:0] lat_of(input int k);
    return (k == 2) ? 32'd3 : (k == 3) ? 32'd2 : 32'd1;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_i(input logic [31:0] data);
    i_exp_q.push_back(data);
    i_due_q.push_back(cyc + lat_of(cur));
  endtask

  task automatic push_d(input logic [31:0] data);
    d_exp_q.push_back(data);
    d_due_q.push_back(cyc + lat_of(cur));
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 4; k++) begin
      i_req[k] = 1'b0; i_flush[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0; d_be[k] = '0;
    end
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
    @(negedge clk);
    check("i_q_left", 32'(i_exp_q.size()), 32'd0);
    check("d_q_left", 32'(d_exp_q.size()), 32'd0);
    i_exp_q.delete(); i_due_q.delete(); d_exp_q.delete(); d_due_q.delete();
    tick();
  endtask

  // scoreboard: every rvalid must match the oldest expected response on its due cycle
  always @(negedge clk) begin
    logic [31:0] exp_v, due_v;
    if (i_rvalid[cur]) begin
      if (i_exp_q.size() == 0) check("i_rvalid_unexp", 32'd1, 32'd0);
      else begin
        exp_v = i_exp_q.pop_front();
        due_v = i_due_q.pop_front();
        check("i_rdata", i_rdata[cur], exp_v);
        check("i_lat", cyc, due_v);
      end
    end else check("i_rdata_idle", i_rdata[cur], 32'd0);
    if (d_rvalid[cur]) begin
      if (d_exp_q.size() == 0) check("d_rvalid_unexp", 32'd1, 32'd0);
      else begin
        exp_v = d_exp_q.pop_front();
        due_v = d_due_q.pop_front();
        check("d_rdata", d_rdata[cur], exp_v);
        check("d_lat", cyc, due_v);
      end
    end else check("d_rdata_idle", d_rdata[cur], 32'd0);
  end

  initial begin
    logic        exp_d, exp_i;
    logic [31:0] a;
    cyc = '0; cur = 0; n_checks = 0; n_errors = 0;
    rst = 4'hF;
    clear_inputs();
    repeat (2) tick();

    // reset holds outputs low even with requests present
    i_req[0] = 1'b1; d_req[0] = 1'b1; i_addr[0] = 32'h40; d_addr[0] = 32'h44;
    @(negedge clk);
    check("rst_i_gnt", 32'(i_gnt[0]), 32'd0);
    check("rst_d_gnt", 32'(d_gnt[0]), 32'd0);
    check("rst_m_req", 32'(m_req[0]), 32'd0);
    check("rst_m_addr", m_addr[0], 32'd0);
    check("rst_state", 32'(fsm_state[0]), 32'd0);
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    tick();
    rst = 4'h0;
    tick();

    // back-to-back fetches at MEM_LAT=1
    for (int j = 0; j < 3; j++) begin
      a = 32'h100 + 32'(4 * j);
      i_req[0] = 1'b1; i_addr[0] = a;
      @(negedge clk);
      check("s1_i_gnt", 32'(i_gnt[0]), 32'd1);
      check("s1_m_addr", m_addr[0], a);
      push_i(a + 32'd1);
      tick();
    end
    i_req[0] = 1'b0;
    drain(3);

    // D fixed priority on conflict, I follows in the response cycle
    i_req[0] = 1'b1; i_addr[0] = 32'h200;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h2000;
    @(negedge clk);
    check("s2_d_gnt", 32'(d_gnt[0]), 32'd1);
    check("s2_i_gnt", 32'(i_gnt[0]), 32'd0);
    check("s2_m_addr", m_addr[0], 32'h2000);
    push_d(32'h2001);
    tick();
    d_req[0] = 1'b0;
    @(negedge clk);
    check("s2_i_gnt2", 32'(i_gnt[0]), 32'd1);
    push_i(32'h201);
    tick();
    i_req[0] = 1'b0;
    drain(3);

    // write: same-cycle completion, no rvalid, pending fetch granted next cycle
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h700; d_wdata[0] = 32'hA5A5_1234; d_be[0] = 4'h3;
    i_req[0] = 1'b1; i_addr[0] = 32'h800;
    @(negedge clk);
    check("wr_d_gnt", 32'(d_gnt[0]), 32'd1);
    check("wr_i_gnt", 32'(i_gnt[0]), 32'd0);
    check("wr_m_we", 32'(m_we[0]), 32'd1);
    check("wr_m_be", 32'(m_be[0]), 32'h3);
    check("wr_m_wdata", m_wdata[0], 32'hA5A5_1234);
    tick();
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    @(negedge clk);
    check("wr_i_gnt2", 32'(i_gnt[0]), 32'd1);
    check("wr_i_m_be", 32'(m_be[0]), 32'hF);
    check("wr_i_m_we", 32'(m_we[0]), 32'd0);
    check("wr_no_rvalid", 32'(d_rvalid[0]), 32'd0);
    push_i(32'h801);
    tick();
    i_req[0] = 1'b0;
    @(negedge clk);
    check("wr_no_rvalid2", 32'(d_rvalid[0]), 32'd0);
    drain(2);

    // random D traffic against a continuously requesting fetch port
    i_req[0] = 1'b1; i_addr[0] = $urandom & 32'hFFFF_FFFC;
    for (int j = 0; j < 12; j++) begin
      d_req[0]   = 1'($urandom_range(0, 1));
      d_we[0]    = 1'($urandom_range(0, 1));
      d_addr[0]  = $urandom & 32'hFFFF_FFFC;
      d_wdata[0] = $urandom;
      d_be[0]    = 4'($urandom_range(1, 15));
      @(negedge clk);
      exp_d = d_req[0];
      check("rnd_d_gnt", 32'(d_gnt[0]), 32'(exp_d));
      check("rnd_i_gnt", 32'(i_gnt[0]), 32'(!exp_d));
      check("rnd_m_addr", m_addr[0], exp_d ? d_addr[0] : i_addr[0]);
      if (exp_d && !d_we[0]) push_d(d_addr[0] + 32'd1);
      if (!exp_d) push_i(i_addr[0] + 32'd1);
      tick();
      if (!exp_d) i_addr[0] = $urandom & 32'hFFFF_FFFC;
    end
    clear_inputs();
    drain(3);

    // round-robin alternation, first conflict goes to I
    cur = 1;
    i_req[1] = 1'b1; i_addr[1] = 32'h300;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h400;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      exp_i = (j % 2 == 0);
      check("rr_i_gnt", 32'(i_gnt[1]), 32'(exp_i));
      check("rr_d_gnt", 32'(d_gnt[1]), 32'(!exp_i));
      if (exp_i) push_i(32'h301); else push_d(32'h401);
      tick();
    end
    clear_inputs();
    drain(3);

    // MEM_LAT=3: no grant until the response cycle
    cur = 2;
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h500;
    @(negedge clk);
    check("l3_d_gnt", 32'(d_gnt[2]), 32'd1);
    push_d(32'h501);
    tick();
    d_req[2] = 1'b0;
    i_req[2] = 1'b1; i_addr[2] = 32'h600;
    for (int j = 1; j < 3; j++) begin
      @(negedge clk);
      check("l3_i_wait", 32'(i_gnt[2]), 32'd0);
      check("l3_m_req", 32'(m_req[2]), 32'd0);
      tick();
    end
    @(negedge clk);
    check("l3_i_gnt", 32'(i_gnt[2]), 32'd1);
    check("l3_d_rvalid", 32'(d_rvalid[2]), 32'd1);
    push_i(32'h601);
    tick();
    i_req[2] = 1'b0;
    drain(5);

    // MEM_LAT=2: flush drops the in-flight fetch response
    cur = 3;
    i_req[3] = 1'b1; i_addr[3] = 32'h900;
    @(negedge clk);
    check("fl_i_gnt", 32'(i_gnt[3]), 32'd1);
    tick();
    i_req[3] = 1'b0; i_flush[3] = 1'b1;
    @(negedge clk);
    check("fl_state_busy", 32'(fsm_state[3]), 32'd1);
    tick();
    i_flush[3] = 1'b0;
    @(negedge clk);
    check("fl_i_rvalid", 32'(i_rvalid[3]), 32'd0);
    check("fl_i_rdata", i_rdata[3], 32'd0);
    tick();
    i_req[3] = 1'b1; i_addr[3] = 32'h980;
    @(negedge clk);
    check("fl_next_gnt", 32'(i_gnt[3]), 32'd1);
    push_i(32'h981);
    tick();
    i_req[3] = 1'b0;
    drain(3);

    // reset mid-transaction loses the response
    i_req[3] = 1'b1; i_addr[3] = 32'hA00;
    @(negedge clk);
    check("mr_i_gnt", 32'(i_gnt[3]), 32'd1);
    tick();
    i_req[3] = 1'b0; rst[3] = 1'b1;
    @(negedge clk);
    check("mr_rst_rvalid", 32'(i_rvalid[3]), 32'd0);
    check("mr_rst_m_req", 32'(m_req[3]), 32'd0);
    tick();
    rst[3] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("mr_no_rvalid", 32'(i_rvalid[3]), 32'd0);
      tick();
    end
    drain(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
